// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: frames arrive in bit-reversed index order, 16 samples per beat,
// and leave in natural order. Output lane l of beat b reads stored index bitrev(b*ARRAY+l).
module fft_bitrev_reorder #(
    parameter int DATA  = 16,
    parameter int ARRAY = 16,
    parameter int LOG2N = 9
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    valid_in,
    input  logic [DATA*ARRAY-1:0]   din_re,
    input  logic [DATA*ARRAY-1:0]   din_im,
    output logic                    valid_out,
    output logic                    sop_out,
    output logic                    eop_out,
    output logic [DATA*ARRAY-1:0]   dout_re,
    output logic [DATA*ARRAY-1:0]   dout_im,
    output logic                    overflow_err
);
    localparam int N     = 1 << LOG2N;
    localparam int BEATS = N / ARRAY;
    localparam int BW    = $clog2(BEATS);
    localparam int LW    = $clog2(ARRAY);

    typedef enum logic {IDLE, READ} state_t;

    logic signed [DATA-1:0] mem_re [2][BEATS][ARRAY];
    logic signed [DATA-1:0] mem_im [2][BEATS][ARRAY];

    logic          wr_bank_q;
    logic [BW-1:0] wr_cnt_q;
    logic [1:0]    bank_full_q, bank_full_d;
    logic          rd_bank_q;
    logic [BW-1:0] rd_cnt_q;
    state_t        state_q;

    logic                  wr_en, wr_last;
    logic                  rd_load, rd_last;
    logic [BW-1:0]         rd_beat;
    logic [DATA*ARRAY-1:0] rd_re, rd_im;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
        return r;
    endfunction

    assign wr_en   = valid_in && !bank_full_q[wr_bank_q];
    assign wr_last = wr_en && (wr_cnt_q == BW'(BEATS-1));
    // In IDLE the beat about to be loaded is always beat 0 of the waiting bank.
    assign rd_beat = (state_q == IDLE) ? '0 : rd_cnt_q;
    assign rd_load = (state_q == READ) || bank_full_q[rd_bank_q];
    assign rd_last = rd_load && (rd_beat == BW'(BEATS-1));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < ARRAY; l++) begin
                mem_re[wr_bank_q][wr_cnt_q][l] <= din_re[l*DATA +: DATA];
                mem_im[wr_bank_q][wr_cnt_q][l] <= din_im[l*DATA +: DATA];
            end
        end
    end

    always_comb begin
        rd_re = '0;
        rd_im = '0;
        for (int l = 0; l < ARRAY; l++) begin
            logic [LOG2N-1:0] idx;
            idx = bitrev({rd_beat, LW'(l)});
            rd_re[l*DATA +: DATA] = mem_re[rd_bank_q][idx[LOG2N-1:LW]][idx[LW-1:0]];
            rd_im[l*DATA +: DATA] = mem_im[rd_bank_q][idx[LOG2N-1:LW]][idx[LW-1:0]];
        end
    end

    // Write sees the pre-release bank_full value; set is applied before clear.
    always_comb begin
        bank_full_d = bank_full_q;
        if (wr_last) bank_full_d[wr_bank_q] = 1'b1;
        if (rd_last) bank_full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_bank_q    <= 1'b0;
            wr_cnt_q     <= '0;
            bank_full_q  <= 2'b00;
            overflow_err <= 1'b0;
        end else begin
            bank_full_q <= bank_full_d;
            if (valid_in && bank_full_q[wr_bank_q]) overflow_err <= 1'b1;
            if (wr_en) begin
                if (wr_last) begin
                    wr_cnt_q  <= '0;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    wr_cnt_q <= wr_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            rd_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
            valid_out <= 1'b0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
            dout_re   <= '0;
            dout_im   <= '0;
        end else begin
            valid_out <= rd_load;
            sop_out   <= rd_load && (rd_beat == '0);
            eop_out   <= rd_last;
            if (rd_load) begin
                dout_re <= rd_re;
                dout_im <= rd_im;
            end
            case (state_q)
                IDLE: begin
                    if (rd_load) begin
                        rd_cnt_q <= BW'(1);
                        state_q  <= READ;
                    end
                end
                READ: begin
                    rd_cnt_q <= rd_cnt_q + 1'b1;
                    if (rd_last) begin
                        rd_bank_q <= ~rd_bank_q;
                        state_q   <= bank_full_q[~rd_bank_q] ? READ : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Randomised bench for the bit-reversal reorder buffer against an index-array reference model.
module tb_fft_bitrev_reorder;
    localparam int DATA = 16, ARRAY = 16, LOG2N = 9;
    localparam int N = 512, BEATS = 32, W = DATA*ARRAY;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         valid_in = 1'b0;
    logic [W-1:0] din_re = '0, din_im = '0;
    logic         valid_out, sop_out, eop_out, overflow_err;
    logic [W-1:0] dout_re, dout_im;

    int vectors = 0;
    int miscompares = 0;

    logic signed [DATA-1:0] fre [4][N];
    logic signed [DATA-1:0] fim [4][N];
    logic [W-1:0]           cap_re [BEATS];

    fft_bitrev_reorder #(.DATA(DATA), .ARRAY(ARRAY), .LOG2N(LOG2N)) dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in), .din_re(din_re), .din_im(din_im),
        .valid_out(valid_out), .sop_out(sop_out), .eop_out(eop_out),
        .dout_re(dout_re), .dout_im(dout_im), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    function automatic int bitrev9(input int x);
        int r = 0;
        int v = x;
        for (int i = 0; i < LOG2N; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic fill(input int f, input bit ramp);
        for (int k = 0; k < N; k++) begin
            if (ramp) begin
                fre[f][k] = DATA'(k + 1000*f);
                fim[f][k] = DATA'(-(k + 1000*f));
            end else begin
                fre[f][k] = DATA'($urandom);
                fim[f][k] = DATA'($urandom);
            end
        end
    endtask

    task automatic drive_beat(input int f, input int b);
        valid_in = 1'b1;
        for (int l = 0; l < ARRAY; l++) begin
            din_re[l*DATA +: DATA] = fre[f][b*ARRAY + l];
            din_im[l*DATA +: DATA] = fim[f][b*ARRAY + l];
        end
    endtask

    task automatic expect_beat(input int f, input int b, output logic [W-1:0] er, output logic [W-1:0] ei);
        for (int l = 0; l < ARRAY; l++) begin
            er[l*DATA +: DATA] = fre[f][bitrev9(b*ARRAY + l)];
            ei[l*DATA +: DATA] = fim[f][bitrev9(b*ARRAY + l)];
        end
    endtask

    task automatic check_beat(input string name, input int f, input int b);
        logic [W-1:0] er, ei;
        logic [2:0]   ec;
        expect_beat(f, b, er, ei);
        ec = {1'b1, b == 0, b == BEATS-1};
        vectors++;
        if ({valid_out, sop_out, eop_out} !== ec || dout_re !== er || dout_im !== ei) begin
            miscompares++;
            $display("FAIL %s f%0d beat%0d: vld/sop/eop=%b want %b re=%h want %h im=%h want %h",
                     name, f, b, {valid_out, sop_out, eop_out}, ec, dout_re, er, dout_im, ei);
        end
    endtask

    // Sends frame f (optionally with a gap after every beat) and checks latency plus all 32 outputs.
    task automatic send_and_check(input string name, input int f, input bit gapped);
        for (int b = 0; b < BEATS; b++) begin
            @(negedge clk); drive_beat(f, b);
            if (gapped && b != BEATS-1) begin
                @(negedge clk); valid_in = 1'b0;
            end
        end
        @(negedge clk); valid_in = 1'b0;
        vectors++;
        if (valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL %s early_valid: valid_out=%b want 0", name, valid_out);
        end
        for (int b = 0; b < BEATS; b++) begin
            @(negedge clk);
            cap_re[b] = dout_re;
            check_beat(name, f, b);
        end
        @(negedge clk);
        vectors++;
        if (valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL %s tail_valid: valid_out=%b want 0", name, valid_out);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({valid_out, sop_out, eop_out, overflow_err} !== 4'b0 || dout_re !== '0 || dout_im !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: ctl=%b re=%h im=%h want all 0",
                     {valid_out, sop_out, eop_out, overflow_err}, dout_re, dout_im);
        end
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (valid_out !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle cycle%0d: valid_out=%b want 0", i, valid_out);
            end
        end
    endtask

    task automatic test_ramp;
        int want [6] = '{0, 256, 128, 384, 16, 511};
        int got  [6];
        fill(0, 1'b1);
        send_and_check("ramp", 0, 1'b0);
        got[0] = int'(signed'(cap_re[0][0*DATA +: DATA]));
        got[1] = int'(signed'(cap_re[0][1*DATA +: DATA]));
        got[2] = int'(signed'(cap_re[0][2*DATA +: DATA]));
        got[3] = int'(signed'(cap_re[0][3*DATA +: DATA]));
        got[4] = int'(signed'(cap_re[1][0*DATA +: DATA]));
        got[5] = int'(signed'(cap_re[31][15*DATA +: DATA]));
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (got[i] !== want[i]) begin
                miscompares++;
                $display("FAIL ramp_spot%0d: re=%0d want %0d", i, got[i], want[i]);
            end
        end
    endtask

    task automatic test_gapped;
        fill(0, 1'b1);
        send_and_check("gapped_ramp", 0, 1'b1);
        fill(1, 1'b0);
        send_and_check("gapped_rand", 1, 1'b1);
    endtask

    task automatic test_back_to_back(input bit ramp);
        for (int f = 0; f < 4; f++) fill(f, ramp);
        fork
            begin
                for (int i = 0; i < 4*BEATS; i++) begin
                    @(negedge clk); drive_beat(i / BEATS, i % BEATS);
                end
                @(negedge clk); valid_in = 1'b0;
            end
            begin
                int t = 0;
                @(negedge clk);
                while (valid_out !== 1'b1 && t < 300) begin
                    @(negedge clk); t++;
                end
                for (int i = 0; i < 4*BEATS; i++) begin
                    if (i > 0) @(negedge clk);
                    check_beat(ramp ? "b2b_ramp" : "b2b_rand", i / BEATS, i % BEATS);
                end
            end
        join
        @(negedge clk);
        vectors++;
        if (overflow_err !== 1'b0 || valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: overflow_err=%b valid_out=%b want 0 0", overflow_err, valid_out);
        end
    endtask

    // Both banks are forced full to emulate a stalled reader; the extra beat must be dropped.
    task automatic test_overflow;
        fill(2, 1'b0);
        @(negedge clk);
        force dut.bank_full_q = 2'b11;
        @(negedge clk); drive_beat(2, 0);
        @(negedge clk); valid_in = 1'b0;
        vectors++;
        if (overflow_err !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_set: overflow_err=%b want 1", overflow_err);
        end
        release dut.bank_full_q;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (overflow_err !== 1'b1) begin
                miscompares++;
                $display("FAIL overflow_sticky cycle%0d: overflow_err=%b want 1", i, overflow_err);
            end
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        vectors++;
        if (overflow_err !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clear: overflow_err=%b want 0", overflow_err);
        end
    endtask

    task automatic test_mid_reset;
        int seen = 0;
        int t = 0;
        fill(3, 1'b0);
        for (int b = 0; b < BEATS; b++) begin
            @(negedge clk); drive_beat(3, b);
        end
        @(negedge clk); valid_in = 1'b0;
        while (seen < 11 && t < 100) begin
            @(negedge clk); t++;
            if (valid_out === 1'b1) seen++;
        end
        rstn = 1'b0;
        #1;
        vectors++;
        if ({valid_out, sop_out, eop_out, overflow_err} !== 4'b0 || dout_re !== '0 || dout_im !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: seen=%0d ctl=%b re=%h want all 0",
                     seen, {valid_out, sop_out, eop_out, overflow_err}, dout_re);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_idle: valid_out=%b want 0", valid_out);
        end
        fill(0, 1'b0);
        send_and_check("after_reset", 0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_ramp;
        test_gapped;
        test_back_to_back(1'b1);
        test_back_to_back(1'b0);
        test_overflow;
        test_mid_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
